// File: rtl/gpo_pad_tx_pkg.sv
// Shared types and helpers for the GPIO pad serial transmitter.
// Optional even-parity bit is enabled by defining GPO_PAD_TX_PARITY_EN.
package gpo_pad_tx_pkg;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned MaxDataW = 16;

  // Level the line rests at whenever it is driven but not carrying a start or data bit.
  localparam logic IdleLevel = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StStart,
    StData,
`ifdef GPO_PAD_TX_PARITY_EN
    StParity,
`endif
    StStop,
    StTrail
  } tx_state_e;

  // Even parity: the XOR of all bits, so the word plus parity has an even count of ones.
  function automatic logic even_parity(input logic [MaxDataW-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/gpo_pad_tx_if.sv
// Word handshake between a producer and the pad transmitter.
interface gpo_pad_tx_if #(
  parameter int unsigned DataW = 8
);
  logic [DataW-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/gpo_pad_tx_bittimer.sv
// Bit-period down-counter: a bit lasts div+1 clocks, bit_tick_o marks its last clock.
module gpo_pad_tx_bittimer #(
  parameter int unsigned DivW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [DivW-1:0] div_i,
  output logic            bit_tick_o
);

  logic [DivW-1:0] cnt_q;

  // Not gated by load_i: tx_ready depends on the tick and load depends on tx_ready.
  assign bit_tick_o = en_i & (cnt_q == '0);

  // Load restarts the bit; otherwise count down and reload at each bit boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= div_i;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_q <= div_i;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpo_pad_tx.sv
// GPIO pad transmit path: frames parallel words as start/data(LSB first)/stop bits with
// output-enable guard intervals. Define GPO_PAD_TX_PARITY_EN to add an even-parity bit.
module gpo_pad_tx
  import gpo_pad_tx_pkg::*;
#(
  parameter int unsigned DataW     = 8,
  parameter int unsigned DivW      = 16,
  parameter int unsigned GuardBits = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [DivW-1:0] div_i,
  gpo_pad_tx_if.slave     bus,
  output logic            busy_o,
  output logic            do_o,
  output logic            oe_o,
  output logic            pu_o
);

  localparam int unsigned MaxBits = (DataW > GuardBits) ? DataW : GuardBits;
  localparam int unsigned CntW    = $clog2(MaxBits) + 1;

  tx_state_e        state_q;
  logic [DataW-1:0] shift_q;
  logic [DataW-1:0] shift_next;
  logic [DivW-1:0]  div_q;
  logic [DivW-1:0]  timer_div;
  logic [CntW-1:0]  bit_cnt_q;
  logic             do_q;
  logic             oe_q;
  logic             pu_q;
  logic             accept;
  logic             bit_tick;
  logic             timer_en;
  logic             last_data;
  logic             last_guard;
`ifdef GPO_PAD_TX_PARITY_EN
  logic             parity_q;
`endif

  assign bus.tx_ready = en_i & ~rst_i &
                        ((state_q == StIdle) || (state_q == StTrail) ||
                         ((state_q == StStop) && bit_tick));
  assign accept       = bus.tx_valid & bus.tx_ready;

  // A freshly accepted divisor must time the very first bit, before div_q updates.
  assign timer_div  = accept ? div_i : div_q;
  assign timer_en   = (state_q != StIdle);
  assign shift_next = shift_q >> 1;
  assign last_data  = (bit_cnt_q == CntW'(DataW - 1));
  assign last_guard = (bit_cnt_q == CntW'(GuardBits - 1));

  gpo_pad_tx_bittimer #(
    .DivW (DivW)
  ) u_bittimer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (timer_en),
    .load_i     (accept),
    .div_i      (timer_div),
    .bit_tick_o (bit_tick)
  );

  // Frame FSM with registered pad outputs set alongside each transition.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      div_q     <= '0;
      bit_cnt_q <= '0;
      do_q      <= IdleLevel;
      oe_q      <= 1'b0;
      pu_q      <= 1'b1;
`ifdef GPO_PAD_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (!en_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      do_q      <= IdleLevel;
      oe_q      <= 1'b0;
      pu_q      <= 1'b1;
    end else begin
      if (accept) begin
        shift_q  <= bus.tx_data;
        div_q    <= div_i;
`ifdef GPO_PAD_TX_PARITY_EN
        parity_q <= even_parity(MaxDataW'(bus.tx_data));
`endif
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q   <= StLead;
            bit_cnt_q <= '0;
            do_q      <= IdleLevel;
            oe_q      <= 1'b1;
            pu_q      <= 1'b0;
          end
        end
        StLead: begin
          if (bit_tick) begin
            if (last_guard) begin
              state_q   <= StStart;
              bit_cnt_q <= '0;
              do_q      <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        StStart: begin
          if (bit_tick) begin
            state_q <= StData;
            do_q    <= shift_q[0];
          end
        end
        StData: begin
          if (bit_tick) begin
            bit_cnt_q <= '0;
            if (last_data) begin
`ifdef GPO_PAD_TX_PARITY_EN
              state_q <= StParity;
              do_q    <= parity_q;
`else
              state_q <= StStop;
              do_q    <= IdleLevel;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              shift_q   <= shift_next;
              do_q      <= shift_next[0];
            end
          end
        end
`ifdef GPO_PAD_TX_PARITY_EN
        StParity: begin
          if (bit_tick) begin
            state_q <= StStop;
            do_q    <= IdleLevel;
          end
        end
`endif
        StStop: begin
          if (bit_tick) begin
            bit_cnt_q <= '0;
            if (accept) begin
              state_q <= StStart;
              do_q    <= 1'b0;
            end else begin
              state_q <= StTrail;
              do_q    <= IdleLevel;
            end
          end
        end
        StTrail: begin
          // A new word here skips the lead guard since the line is already driven.
          if (accept) begin
            state_q   <= StStart;
            bit_cnt_q <= '0;
            do_q      <= 1'b0;
          end else if (bit_tick) begin
            if (last_guard) begin
              state_q   <= StIdle;
              bit_cnt_q <= '0;
              do_q      <= IdleLevel;
              oe_q      <= 1'b0;
              pu_q      <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          do_q    <= IdleLevel;
          oe_q    <= 1'b0;
          pu_q    <= 1'b1;
        end
      endcase
    end
  end

  assign do_o   = do_q;
  assign oe_o   = oe_q;
  assign pu_o   = pu_q;
  assign busy_o = oe_q;

endmodule

// File: tb/tb_gpo_pad_tx.sv
// Self-checking bench for gpo_pad_tx: vector table, hand-written corner sequences and
// random frames, all compared against a bit-list model of the serial line.
module tb_gpo_pad_tx;

  localparam int unsigned DataW = 8;
  localparam int unsigned DivW  = 16;
  localparam int unsigned G     = 1;
`ifdef GPO_PAD_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // Bits from start to stop inclusive.
  localparam int Body = DataW + 2 + P;

  logic            clk;
  logic            rst;
  logic            en;
  logic [DivW-1:0] div;
  logic            busy;
  logic            pad_do;
  logic            oe;
  logic            pu;

  gpo_pad_tx_if #(.DataW(DataW)) bus ();

  gpo_pad_tx #(
    .DataW     (DataW),
    .DivW      (DivW),
    .GuardBits (G)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .div_i  (div),
    .bus    (bus),
    .busy_o (busy),
    .do_o   (pad_do),
    .oe_o   (oe),
    .pu_o   (pu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected line level for every clock of one OE window.
  bit exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         div;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_bit(input bit v, input int d);
    for (int r = 0; r <= d; r++) exp_q.push_back(v);
  endfunction

  // Line model: lead guard, frames (optionally separated by gap idle clocks), trail guard.
  function automatic void build_line(input logic [7:0] w0, input logic [7:0] w1,
                                     input int nw, input int d, input int gap);
    logic [7:0] w;
    exp_q = {};
    for (int g = 0; g < int'(G); g++) push_bit(1'b1, d);
    for (int f = 0; f < nw; f++) begin
      w = (f == 0) ? w0 : w1;
      if (f == 1) for (int c = 0; c < gap; c++) exp_q.push_back(1'b1);
      push_bit(1'b0, d);
      for (int b = 0; b < int'(DataW); b++) push_bit(w[b], d);
      if (P != 0) push_bit(^w, d);
      push_bit(1'b1, d);
    end
    for (int g = 0; g < int'(G); g++) push_bit(1'b1, d);
  endfunction

  // Drive one or two words and check every clock of the resulting OE window.
  // hold: keep valid asserted so word 2 goes back-to-back; otherwise word 2 is offered
  // at window index v2_at.
  task automatic run_seq(input string name, input logic [7:0] w0, input logic [7:0] w1,
                         input int nw, input int d, input bit hold, input int v2_at,
                         input int gap, input int exp_len);
    int  k;
    int  cnt;
    int  guard;
    bit  pending;
    bit  seen;
    build_line(w0, w1, nw, d, gap);
    @(negedge clk);
    bus.tx_data  = w0;
    div          = DivW'(d);
    bus.tx_valid = 1'b1;
    k = 0; cnt = 0; guard = 0; pending = 0; seen = 0;
    while (guard < 4000) begin
      if (oe) begin
        if (cnt < exp_q.size())
          check({name, " line"}, 32'({oe, pad_do, pu, busy}), 32'({1'b1, exp_q[cnt], 1'b0, 1'b1}));
        cnt++;
        seen = 1;
      end else if (seen) begin
        break;
      end
      if (pending) begin
        pending = 0;
        k++;
        if (hold && k < nw) bus.tx_data = w1;
        else bus.tx_valid = 1'b0;
      end
      if (!hold && nw == 2 && k == 1 && oe && (cnt - 1) == v2_at) begin
        bus.tx_data  = w1;
        bus.tx_valid = 1'b1;
      end
      if (bus.tx_valid && bus.tx_ready) pending = 1;
      @(negedge clk);
      guard++;
    end
    bus.tx_valid = 1'b0;
    check({name, " timeout"}, 32'(guard >= 4000), 32'(0));
    check({name, " oe window"}, 32'(cnt), 32'(exp_len));
    check({name, " words taken"}, 32'(k), 32'(nw));
    check({name, " idle after"}, 32'({oe, pad_do, pu, busy, bus.tx_ready}), 32'(5'b01101));
  endtask

  initial begin
    logic [7:0] r0;
    logic [7:0] r1;
    int         rd;
    int         rn;

    vecs[0] = '{8'hA5, 3, 48 + 4 * P};
    vecs[1] = '{8'h00, 0, 12 + P};
    vecs[2] = '{8'hFF, 1, 24 + 2 * P};
    vecs[3] = '{8'h5A, 2, 36 + 3 * P};
    vecs[4] = '{8'h81, 4, 60 + 5 * P};
    vecs[5] = '{8'h07, 1, 24 + 2 * P};
    vecs[6] = '{8'h03, 1, 24 + 2 * P};

    rst          = 1'b1;
    en           = 1'b1;
    div          = '0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    #1;
    check("reset outputs", 32'({oe, pad_do, pu, busy, bus.tx_ready}), 32'(5'b01100));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready after reset", 32'({oe, bus.tx_ready}), 32'(2'b01));

    foreach (vecs[i])
      run_seq($sformatf("vec%0d", i), vecs[i].data, 8'h00, 1, vecs[i].div, 1'b1, 0, 0,
              vecs[i].exp_len);

    // Two held words at one clock per bit: a single 22-clock window, no idle bit between.
    run_seq("b2b", 8'h00, 8'hFF, 2, 0, 1'b1, 0, 0, 22 + 2 * P);

    // Second word offered two clocks into TRAIL: no lead guard, OE stays high.
    run_seq("trail", 8'h3C, 8'hC3, 2, 3, 1'b0, (int'(G) + Body) * 4 + 1, 2,
            2 * int'(G) * 4 + 2 * Body * 4 + 2);

    // Reset mid-DATA: pad outputs return to reset values without waiting for an edge.
    @(negedge clk);
    bus.tx_data = 8'hA5; div = 16'd3; bus.tx_valid = 1'b1;
    check("rst accept ready", 32'(bus.tx_ready), 32'(1));
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("rst mid data oe", 32'(oe), 32'(1));
    rst = 1'b1;
    #1;
    check("rst mid data", 32'({oe, pad_do, pu, busy, bus.tx_ready}), 32'(5'b01100));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst release", 32'({oe, pad_do, pu, busy, bus.tx_ready}), 32'(5'b01101));

    // Enable dropped during data bit 3: abort, no accept while low, no resend.
    @(negedge clk);
    bus.tx_data = 8'hA5; div = 16'd3; bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (21) @(negedge clk);
    en = 1'b0;
    bus.tx_data = 8'h3C;
    bus.tx_valid = 1'b1;
    #1;
    check("en low ready", 32'(bus.tx_ready), 32'(0));
    @(negedge clk);
    check("en abort", 32'({oe, pad_do, pu, busy, bus.tx_ready}), 32'(5'b01100));
    repeat (3) @(negedge clk);
    check("en held low", 32'({oe, pad_do, pu, busy, bus.tx_ready}), 32'(5'b01100));
    bus.tx_valid = 1'b0;
    en = 1'b1;
    #1;
    check("en return ready", 32'(bus.tx_ready), 32'(1));
    repeat (3) @(negedge clk);
    check("no resend", 32'({oe, pad_do, pu}), 32'(3'b011));

    // Random frames, single or back-to-back, against the line model.
    for (int it = 0; it < 10; it++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      rd = int'($urandom_range(0, 4));
      rn = int'($urandom_range(1, 2));
      run_seq($sformatf("rand%0d", it), r0, r1, rn, rd, 1'b1, 0, 0,
              (rd + 1) * (2 * int'(G) + rn * Body));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
